// File: rtl/panda_risc_v_reg_file_rd_arb_if.sv
// Register-file access bundle: write-back port, two decoder read ports, one IFU read port.
// The master side is the requester (decoder/IFU/write-back); the slave side is the register file.
interface panda_risc_v_reg_file_rd_arb_if;
  logic        reg_file_wen;
  logic [4:0]  reg_file_waddr;
  logic [31:0] reg_file_din;

  logic        dcd_reg_file_rd_p0_req;
  logic [4:0]  dcd_reg_file_rd_p0_addr;
  logic        dcd_reg_file_rd_p0_grant;
  logic [31:0] dcd_reg_file_rd_p0_dout;

  logic        dcd_reg_file_rd_p1_req;
  logic [4:0]  dcd_reg_file_rd_p1_addr;
  logic        dcd_reg_file_rd_p1_grant;
  logic [31:0] dcd_reg_file_rd_p1_dout;

  logic        ifu_reg_file_rd_req;
  logic [4:0]  ifu_reg_file_rd_addr;
  logic        ifu_reg_file_rd_grant;
  logic [31:0] ifu_reg_file_rd_dout;

  modport master (
    output reg_file_wen, reg_file_waddr, reg_file_din,
    output dcd_reg_file_rd_p0_req, dcd_reg_file_rd_p0_addr,
    input  dcd_reg_file_rd_p0_grant, dcd_reg_file_rd_p0_dout,
    output dcd_reg_file_rd_p1_req, dcd_reg_file_rd_p1_addr,
    input  dcd_reg_file_rd_p1_grant, dcd_reg_file_rd_p1_dout,
    output ifu_reg_file_rd_req, ifu_reg_file_rd_addr,
    input  ifu_reg_file_rd_grant, ifu_reg_file_rd_dout
  );

  modport slave (
    input  reg_file_wen, reg_file_waddr, reg_file_din,
    input  dcd_reg_file_rd_p0_req, dcd_reg_file_rd_p0_addr,
    output dcd_reg_file_rd_p0_grant, dcd_reg_file_rd_p0_dout,
    input  dcd_reg_file_rd_p1_req, dcd_reg_file_rd_p1_addr,
    output dcd_reg_file_rd_p1_grant, dcd_reg_file_rd_p1_dout,
    input  ifu_reg_file_rd_req, ifu_reg_file_rd_addr,
    output ifu_reg_file_rd_grant, ifu_reg_file_rd_dout
  );
endinterface

// File: rtl/panda_risc_v_reg_file_rd_arb.sv
// 32x32 register file with zero-latency reads; port 0 shared between decoder p0 and IFU under
// fixed priority with anti-starvation. Define REG_FILE_WR_BYPASS_EN for same-cycle write-to-read forwarding.
module panda_risc_v_reg_file_rd_arb #(
  parameter int STARVE_TH = 4
) (
  input  logic                               clk,
  input  logic                               sys_reset,
  panda_risc_v_reg_file_rd_arb_if.slave      rf
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_TH);

  logic [31:0] regs_q [0:31];
  logic [3:0]  starve_q, starve_d;
  logic        ifu_force;
  logic        p0_gnt, ifu_gnt;
  logic [31:0] p0_rd, p1_rd, ifu_rd;

  // regs_q[0] is never written, so it reads as zero without a special case.
  always_ff @(posedge clk) begin
    if (sys_reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      starve_q <= '0;
    end else begin
      if (rf.reg_file_wen && rf.reg_file_waddr != 5'd0)
        regs_q[rf.reg_file_waddr] <= rf.reg_file_din;
      starve_q <= starve_d;
    end
  end

  assign ifu_force = (starve_q == STARVE_LIM);
  assign p0_gnt    = rf.dcd_reg_file_rd_p0_req && !(rf.ifu_reg_file_rd_req && ifu_force);
  assign ifu_gnt   = rf.ifu_reg_file_rd_req && (!rf.dcd_reg_file_rd_p0_req || ifu_force);

  always_comb begin
    starve_d = '0;
    if (rf.ifu_reg_file_rd_req && !ifu_gnt)
      starve_d = ifu_force ? starve_q : starve_q + 4'd1;
  end

`ifdef REG_FILE_WR_BYPASS_EN
  always_comb begin
    p0_rd  = regs_q[rf.dcd_reg_file_rd_p0_addr];
    p1_rd  = regs_q[rf.dcd_reg_file_rd_p1_addr];
    ifu_rd = regs_q[rf.ifu_reg_file_rd_addr];
    if (rf.reg_file_wen && rf.reg_file_waddr != 5'd0) begin
      if (rf.reg_file_waddr == rf.dcd_reg_file_rd_p0_addr) p0_rd  = rf.reg_file_din;
      if (rf.reg_file_waddr == rf.dcd_reg_file_rd_p1_addr) p1_rd  = rf.reg_file_din;
      if (rf.reg_file_waddr == rf.ifu_reg_file_rd_addr)    ifu_rd = rf.reg_file_din;
    end
  end
`else
  always_comb begin
    p0_rd  = regs_q[rf.dcd_reg_file_rd_p0_addr];
    p1_rd  = regs_q[rf.dcd_reg_file_rd_p1_addr];
    ifu_rd = regs_q[rf.ifu_reg_file_rd_addr];
  end
`endif

  assign rf.dcd_reg_file_rd_p0_grant = !sys_reset && p0_gnt;
  assign rf.dcd_reg_file_rd_p1_grant = !sys_reset && rf.dcd_reg_file_rd_p1_req;
  assign rf.ifu_reg_file_rd_grant    = !sys_reset && ifu_gnt;

  assign rf.dcd_reg_file_rd_p0_dout  = sys_reset ? 32'd0 : p0_rd;
  assign rf.dcd_reg_file_rd_p1_dout  = sys_reset ? 32'd0 : p1_rd;
  assign rf.ifu_reg_file_rd_dout     = sys_reset ? 32'd0 : ifu_rd;

endmodule

// File: tb/tb_panda_risc_v_reg_file_rd_arb.sv
// Directed bench for the register file / port-0 arbiter; expected values are hand-derived.
module tb_panda_risc_v_reg_file_rd_arb;
  logic clk = 1'b0;
  logic sys_reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  panda_risc_v_reg_file_rd_arb_if bus ();

  panda_risc_v_reg_file_rd_arb #(.STARVE_TH(4)) dut (
    .clk       (clk),
    .sys_reset (sys_reset),
    .rf        (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed 1 ns after the edge, outputs checked 2 ns after.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.reg_file_wen            = 1'b0;
    bus.reg_file_waddr          = 5'd0;
    bus.reg_file_din            = 32'd0;
    bus.dcd_reg_file_rd_p0_req  = 1'b0;
    bus.dcd_reg_file_rd_p0_addr = 5'd0;
    bus.dcd_reg_file_rd_p1_req  = 1'b0;
    bus.dcd_reg_file_rd_p1_addr = 5'd0;
    bus.ifu_reg_file_rd_req     = 1'b0;
    bus.ifu_reg_file_rd_addr    = 5'd0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.reg_file_wen   = 1'b1;
    bus.reg_file_waddr = a;
    bus.reg_file_din   = d;
  endtask

  // Contention run: expected IFU grant bit per cycle, dcd p0 expected to be its complement.
  task automatic contend(input string tag, input int n, input logic [15:0] ifu_pat);
    for (int i = 0; i < n; i++) begin
      bus.dcd_reg_file_rd_p0_req = 1'b1;
      bus.ifu_reg_file_rd_req    = 1'b1;
      #1;
      check($sformatf("%s_ifu_gnt%0d", tag, i), 32'(bus.ifu_reg_file_rd_grant), 32'(ifu_pat[i]));
      check($sformatf("%s_p0_gnt%0d", tag, i), 32'(bus.dcd_reg_file_rd_p0_grant), 32'(!ifu_pat[i]));
      step();
    end
  endtask

  initial begin
    sys_reset = 1'b1;
    idle();
    step();
    // Requests during reset must not be granted and data is forced to zero
    bus.dcd_reg_file_rd_p0_req  = 1'b1;
    bus.dcd_reg_file_rd_p1_req  = 1'b1;
    bus.ifu_reg_file_rd_req     = 1'b1;
    #1;
    check("rst_p0_gnt", 32'(bus.dcd_reg_file_rd_p0_grant), 32'd0);
    check("rst_p1_gnt", 32'(bus.dcd_reg_file_rd_p1_grant), 32'd0);
    check("rst_ifu_gnt", 32'(bus.ifu_reg_file_rd_grant), 32'd0);
    check("rst_p0_dout", bus.dcd_reg_file_rd_p0_dout, 32'd0);
    step();
    sys_reset = 1'b0;
    idle();

    // Write x5, reset for one cycle, then x5 must read zero
    wr(5'd5, 32'h1234);
    step();
    idle();
    bus.dcd_reg_file_rd_p0_req  = 1'b1;
    bus.dcd_reg_file_rd_p0_addr = 5'd5;
    #1;
    check("x5_written", bus.dcd_reg_file_rd_p0_dout, 32'h1234);
    sys_reset = 1'b1;
    step();
    sys_reset = 1'b0;
    #1;
    check("x5_rst_gnt", 32'(bus.dcd_reg_file_rd_p0_grant), 32'd1);
    check("x5_rst_dout", bus.dcd_reg_file_rd_p0_dout, 32'd0);
    idle();

    // x0 is hard-wired to zero
    wr(5'd0, 32'hFFFF_FFFF);
    step();
    idle();
    bus.dcd_reg_file_rd_p0_req = 1'b1;
    bus.dcd_reg_file_rd_p1_req = 1'b1;
    #1;
    check("x0_p0_gnt", 32'(bus.dcd_reg_file_rd_p0_grant), 32'd1);
    check("x0_p0_dout", bus.dcd_reg_file_rd_p0_dout, 32'd0);
    check("x0_p1_gnt", 32'(bus.dcd_reg_file_rd_p1_grant), 32'd1);
    check("x0_p1_dout", bus.dcd_reg_file_rd_p1_dout, 32'd0);
    step();
    idle();
    bus.ifu_reg_file_rd_req = 1'b1;
    #1;
    check("x0_ifu_gnt", 32'(bus.ifu_reg_file_rd_grant), 32'd1);
    check("x0_ifu_dout", bus.ifu_reg_file_rd_dout, 32'd0);
    step();
    idle();

    // Write-then-read of x7 in the same cycle
    wr(5'd7, 32'h11);
    step();
    wr(5'd7, 32'h22);
    bus.dcd_reg_file_rd_p0_req  = 1'b1;
    bus.dcd_reg_file_rd_p0_addr = 5'd7;
    #1;
`ifdef REG_FILE_WR_BYPASS_EN
    check("byp_same", bus.dcd_reg_file_rd_p0_dout, 32'h22);
`else
    check("byp_same", bus.dcd_reg_file_rd_p0_dout, 32'h11);
`endif
    step();
    bus.reg_file_wen = 1'b0;
    #1;
    check("byp_next", bus.dcd_reg_file_rd_p0_dout, 32'h22);
    idle();

    // Dual read on the two physical ports
    wr(5'd3, 32'hA);
    step();
    wr(5'd4, 32'hB);
    step();
    idle();
    bus.dcd_reg_file_rd_p0_req  = 1'b1;
    bus.dcd_reg_file_rd_p0_addr = 5'd3;
    bus.dcd_reg_file_rd_p1_req  = 1'b1;
    bus.dcd_reg_file_rd_p1_addr = 5'd4;
    #1;
    check("dual_p0_gnt", 32'(bus.dcd_reg_file_rd_p0_grant), 32'd1);
    check("dual_p1_gnt", 32'(bus.dcd_reg_file_rd_p1_grant), 32'd1);
    check("dual_p0_dout", bus.dcd_reg_file_rd_p0_dout, 32'hA);
    check("dual_p1_dout", bus.dcd_reg_file_rd_p1_dout, 32'hB);
    step();
    idle();

    // Continuous contention: 4 dcd wins, forced IFU win, 4 more dcd wins
    bus.ifu_reg_file_rd_addr = 5'd4;
    contend("cont", 4, 16'b0000);
    bus.dcd_reg_file_rd_p0_req = 1'b1;
    bus.ifu_reg_file_rd_req    = 1'b1;
    #1;
    check("cont_ifu_dout", bus.ifu_reg_file_rd_dout, 32'hB);
    #0;
    contend("cont_win", 1, 16'b1);
    contend("cont_post", 4, 16'b0000);
    idle();
    step();

    // Dropping the IFU request clears the starvation count
    contend("clr_a", 3, 16'b000);
    bus.ifu_reg_file_rd_req = 1'b0;
    #1;
    check("clr_drop_p0_gnt", 32'(bus.dcd_reg_file_rd_p0_grant), 32'd1);
    step();
    contend("clr_b", 5, 16'b10000);
    idle();
    step();

    // Reset in the middle of contention: grants drop at once, count restarts
    contend("mid_a", 2, 16'b00);
    bus.dcd_reg_file_rd_p0_req = 1'b1;
    bus.ifu_reg_file_rd_req    = 1'b1;
    sys_reset = 1'b1;
    #1;
    check("mid_rst_p0_gnt", 32'(bus.dcd_reg_file_rd_p0_grant), 32'd0);
    check("mid_rst_ifu_gnt", 32'(bus.ifu_reg_file_rd_grant), 32'd0);
    step();
    sys_reset = 1'b0;
    contend("mid_b", 5, 16'b10000);
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
